// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline registers:
// control-bundle layout, default widths and occupancy encodings.
package pipe_pkg;

    // Control bundle layout (bit offsets within ctrl).
    localparam int unsigned CTRL_REG_WRITE = 0;
    localparam int unsigned CTRL_MEM_TO_REG = 1;
    localparam int unsigned CTRL_MEM_READ = 2;
    localparam int unsigned CTRL_MEM_WRITE = 3;
    localparam int unsigned CTRL_BRANCH = 4;
    localparam int unsigned CTRL_ALU_SRC = 5;
    localparam int unsigned CTRL_REG_DST = 6;
    localparam int unsigned CTRL_ALU_OP_LSB = 7;
    localparam int unsigned CTRL_ALU_OP_W = 2;
    localparam int unsigned SIG_SIZE = CTRL_ALU_OP_LSB + CTRL_ALU_OP_W;

    localparam int unsigned DEFAULT_PC_W = 16;

    // Per-stage payload widths so every instance packs payloads identically.
    localparam int unsigned IF_ID_DATA_W = 32;
    localparam int unsigned ID_EX_DATA_W = 106;
    localparam int unsigned EX_MEM_DATA_W = 48;
    localparam int unsigned MEM_WB_DATA_W = 37;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE = 2'd1;
    localparam logic [1:0] OCC_FULL = 2'd2;

    // Encoded as {main_v, skid_v}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne = 2'b10,
        StFull = 2'b11
    } occ_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline register slot (valid, pc, data, ctrl) with load, clear and
// asynchronous reset. Clear always zeroes ctrl; pc/data only if ZERO_INVALID.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned PC_W = DEFAULT_PC_W,
    parameter int unsigned DATA_W = EX_MEM_DATA_W,
    parameter int unsigned CTRL_W = SIG_SIZE,
    parameter bit ZERO_INVALID = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q;
    logic [PC_W-1:0]   pc_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            if (ZERO_INVALID) begin
                pc_q   <= '0;
                data_q <= '0;
            end
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            data_q  <= data_i;
            ctrl_q  <= ctrl_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register: main slot plus one skid slot, valid/ready.
// Optional PIPE_STAGE_PERF_EN adds saturating stall and flush counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned PC_W = DEFAULT_PC_W,
    parameter int unsigned DATA_W = EX_MEM_DATA_W,
    parameter int unsigned CTRL_W = SIG_SIZE,
    parameter bit ZERO_INVALID = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PC_W-1:0]   in_pc_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   out_pc_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occupancy_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]       stall_cnt_o,
    output logic [15:0]       flush_cnt_o
`endif
);

    logic              main_v, skid_v;
    logic [PC_W-1:0]   skid_pc;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              main_load, main_clear, skid_load, skid_clear, main_from_skid;
    logic [PC_W-1:0]   main_pc_d;
    logic [DATA_W-1:0] main_data_d;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic              acc, drn;
    occ_state_e        state;

    assign state      = occ_state_e'({main_v, skid_v});
    assign in_ready_o = ~skid_v;
    assign acc        = in_valid_i & in_ready_o;
    assign drn        = main_v & out_ready_i;

    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        main_from_skid = 1'b0;
        occupancy_o    = OCC_ONE;
        unique case (state)
            StEmpty: occupancy_o = OCC_EMPTY;
            StOne:   occupancy_o = OCC_ONE;
            StFull:  occupancy_o = OCC_FULL;
            default: occupancy_o = OCC_ONE;
        endcase
        if (flush_i) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                StEmpty: main_load = acc;
                StOne: begin
                    main_load  = acc & drn;
                    skid_load  = acc & ~drn;
                    main_clear = ~acc & drn;
                end
                StFull: begin
                    main_load      = drn;
                    main_from_skid = drn;
                    skid_clear     = drn;
                end
                default: ;
            endcase
        end
    end

    assign main_pc_d   = main_from_skid ? skid_pc : in_pc_i;
    assign main_data_d = main_from_skid ? skid_data : in_data_i;
    assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl_i;

    pipe_slot #(
        .PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .ZERO_INVALID(ZERO_INVALID)
    ) u_main (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .load_i (main_load),
        .clear_i(main_clear),
        .pc_i   (main_pc_d),
        .data_i (main_data_d),
        .ctrl_i (main_ctrl_d),
        .valid_o(main_v),
        .pc_o   (out_pc_o),
        .data_o (out_data_o),
        .ctrl_o (out_ctrl_o)
    );

    pipe_slot #(
        .PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .ZERO_INVALID(ZERO_INVALID)
    ) u_skid (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .load_i (skid_load),
        .clear_i(skid_clear),
        .pc_i   (in_pc_i),
        .data_i (in_data_i),
        .ctrl_i (in_ctrl_i),
        .valid_o(skid_v),
        .pc_o   (skid_pc),
        .data_o (skid_data),
        .ctrl_o (skid_ctrl)
    );

    assign out_valid_o = main_v;

    skid_needs_main: assert property (@(posedge clk_i) disable iff (reset_i) !(skid_v && !main_v));

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_v && !out_ready_i && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush_i && main_v && flush_cnt_q != 16'hFFFF) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a capacity-2 FIFO model tracks what must
// appear at the output; a negedge monitor compares and pops on each transfer.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int unsigned PW = 16;
    localparam int unsigned DW = EX_MEM_DATA_W;
    localparam int unsigned CW = SIG_SIZE;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_pc = '0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid;
    logic [PW-1:0] out_pc;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;
    logic          nz_in_ready, nz_out_valid;
    logic [PW-1:0] nz_out_pc;
    logic [DW-1:0] nz_out_data;
    logic [CW-1:0] nz_out_ctrl;
    logic [1:0]    nz_occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0]   stall_cnt, flush_cnt, nz_stall_cnt, nz_flush_cnt;
`endif

    int unsigned   total = 0;
    int unsigned   bad = 0;
    bit            mon_en = 1'b0;
    ent_t          expq[$];
    logic [15:0]   stall_m = '0;
    logic [15:0]   flush_m = '0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.PC_W(PW), .DATA_W(DW), .CTRL_W(CW), .ZERO_INVALID(1'b1)) dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_pc_i(in_pc), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc),
        .out_data_o(out_data), .out_ctrl_o(out_ctrl), .occupancy_o(occupancy)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
    );

    pipe_stage_skid #(.PC_W(PW), .DATA_W(DW), .CTRL_W(CW), .ZERO_INVALID(1'b0)) dut_nz (
        .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(nz_in_ready), .in_pc_i(in_pc), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .out_valid_o(nz_out_valid), .out_ready_i(out_ready), .out_pc_o(nz_out_pc),
        .out_data_o(nz_out_data), .out_ctrl_o(nz_out_ctrl), .occupancy_o(nz_occupancy)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(nz_stall_cnt), .flush_cnt_o(nz_flush_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and advance the reference FIFO past the edge.
    task automatic cycle(input logic iv, input logic [PW-1:0] pc, input logic ordy,
                         input logic fl);
        ent_t e;
        bit   acc;
        int   occ;
        @(negedge clk);
        e.pc = pc;
        e.data = DW'({$urandom, $urandom});
        e.ctrl = CW'($urandom);
        in_valid = iv;
        in_pc = pc;
        in_data = e.data;
        in_ctrl = e.ctrl;
        out_ready = ordy;
        flush = fl;
        occ = expq.size();
        acc = iv && (occ < 2) && !fl;
        @(posedge clk);
        #1;
        if (occ > 0 && !ordy && stall_m != 16'hFFFF) stall_m++;
        if (fl && occ > 0) flush_m++;
        if (fl) expq.delete();
        else if (acc) expq.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_occupancy", occupancy, 0);
        expq.delete();
        stall_m = '0;
        flush_m = '0;
        @(negedge clk);
        #3 reset = 1'b0;
    endtask

    initial begin : monitor
        int sz;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && !reset) begin
                sz = expq.size();
                chk("occupancy", occupancy, sz);
                chk("in_ready", in_ready, sz < 2);
                chk("out_valid", out_valid, sz > 0);
                chk("nz_out_valid", nz_out_valid, sz > 0);
                chk("nz_in_ready", nz_in_ready, sz < 2);
                if (sz > 0) begin
                    chk("out_pc", out_pc, expq[0].pc);
                    chk("out_data", out_data, expq[0].data);
                    chk("out_ctrl", out_ctrl, expq[0].ctrl);
                    chk("nz_out_pc", nz_out_pc, expq[0].pc);
                    chk("nz_out_ctrl", nz_out_ctrl, expq[0].ctrl);
                    if (out_ready) void'(expq.pop_front());
                end else begin
                    chk("idle_out_pc", out_pc, 0);
                    chk("idle_out_data", out_data, 0);
                    chk("idle_out_ctrl", out_ctrl, 0);
                    chk("nz_idle_out_ctrl", nz_out_ctrl, 0);
                end
`ifdef PIPE_STAGE_PERF_EN
                chk("stall_cnt", stall_cnt, stall_m);
                chk("flush_cnt", flush_cnt, flush_m);
                chk("nz_stall_cnt", nz_stall_cnt, stall_m);
`endif
            end
        end
    end

    initial begin : stim
        repeat (2) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_in_ready", in_ready, 1);
        chk("init_occupancy", occupancy, 0);
        chk("init_out_ctrl", out_ctrl, 0);
        mon_en = 1'b1;

        // Fill both slots, then reset between edges.
        cycle(1'b1, 16'h0010, 1'b0, 1'b0);
        cycle(1'b1, 16'h0012, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("full_occupancy", occupancy, 2);
        do_reset();

        // Streaming at full rate.
        for (int i = 0; i < 8; i++) cycle(1'b1, PW'(i), 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        // Backpressure into the skid slot, then release.
        cycle(1'b1, 16'h0020, 1'b0, 1'b0);
        cycle(1'b1, 16'h0022, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush while full with a new input presented.
        cycle(1'b1, 16'h0024, 1'b0, 1'b0);
        cycle(1'b1, 16'h0026, 1'b0, 1'b0);
        cycle(1'b1, 16'h0030, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 16'h0000, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 7, PW'($urandom), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0);
        end
        repeat (3) cycle(1'b0, 16'h0000, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
        do_reset();
        cycle(1'b1, 16'h0040, 1'b0, 1'b0);
        repeat (70000) cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("stall_saturated", stall_cnt, 16'hFFFF);
        do_reset();
        repeat (3) begin
            cycle(1'b1, 16'h0050, 1'b0, 1'b0);
            cycle(1'b0, 16'h0000, 1'b1, 1'b1);
        end
        cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("flush_cnt_three", flush_cnt, 3);
`endif

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
